// File: rtl/unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// unidade_controle_rodadas
//
// Moore control unit for a round-based memory game. In round k the player
// repeats positions 0..k of the stored sequence. It drives the move counter
// (E), the round-limit counter (L) and the move register (R) of the datapath,
// and ends in one of three outcomes: won, wrong move or move timeout.
//
// Parameters
//   TIMEOUT_EN      1 enables the per-move timeout, 0 waits forever for a move
//   TIMEOUT_CICLOS  clock cycles allowed per move (>= 2)
//
// Ports
//   clock, reset_n        clock (rising edge), asynchronous active-low reset
//   iniciar               level, starts/restarts from inicial or a fim state
//   jogada                one-cycle pulse, a move was made
//   igual, fimE, fimL     datapath status flags
//   zeraE/contaE          clear / increment move counter E
//   zeraL/contaL          clear / increment round-limit counter L
//   zeraR/registraR       clear / load move register R
//   pronto, ganhou,       game over, won, lost (wrong move or timeout),
//   perdeu, db_timeout    lost by timeout
//   db_estado             state code for debug
// -----------------------------------------------------------------------------
module unidade_controle_rodadas #(
    parameter bit TIMEOUT_EN     = 1'b1,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam int            TW        = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        INICIO_RODADA = 4'h2,
        ESPERA_JOGADA = 4'h3,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMO       = 4'h6,
        FIM_RODADA    = 4'h7,
        FIM_GANHOU    = 4'hA,
        FIM_TIMEOUT   = 4'hB,
        FIM_PERDEU    = 4'hE
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            timeout_hit;

    // The timer compare is the only non-state term feeding next-state logic.
    assign timeout_hit = TIMEOUT_EN && (timer_q == TIMER_MAX);

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL:       if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:    estado_d = INICIO_RODADA;
            INICIO_RODADA: estado_d = ESPERA_JOGADA;
            // A move in the same cycle as the timeout takes priority.
            ESPERA_JOGADA: begin
                if (jogada)           estado_d = REGISTRA;
                else if (timeout_hit) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:      estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)             estado_d = FIM_PERDEU;
                else if (fimE && fimL)  estado_d = FIM_GANHOU;
                else if (fimE)          estado_d = FIM_RODADA;
                else                    estado_d = PROXIMO;
            end
            PROXIMO:       estado_d = ESPERA_JOGADA;
            FIM_RODADA:    estado_d = INICIO_RODADA;
            FIM_GANHOU,
            FIM_PERDEU,
            FIM_TIMEOUT:   if (iniciar) estado_d = PREPARACAO;
            default:       estado_d = INICIAL;
        endcase
    end

    // Timer counts only while remaining in espera_jogada, so every fresh
    // entry (from inicio_rodada or proximo) starts from zero. It saturates
    // rather than wrapping, which matters when the timeout is disabled.
    always_comb begin
        timer_d = '0;
        if (estado_q == ESPERA_JOGADA && estado_d == ESPERA_JOGADA) begin
            if (timer_q == TIMER_MAX) timer_d = timer_q;
            else                      timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    // Moore decode: outputs depend on the state register only, so an
    // asynchronous reset drops every final flag immediately.
    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraL      = 1'b0;
        contaL     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        db_estado  = 4'hF;
        unique case (estado_q)
            INICIAL: begin
                zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1;
                db_estado = 4'h0;
            end
            PREPARACAO: begin
                zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1;
                db_estado = 4'h1;
            end
            INICIO_RODADA: begin
                zeraE = 1'b1;
                db_estado = 4'h2;
            end
            ESPERA_JOGADA: db_estado = 4'h3;
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO:    db_estado = 4'h5;
            PROXIMO: begin
                contaE = 1'b1;
                db_estado = 4'h6;
            end
            FIM_RODADA: begin
                contaL = 1'b1;
                db_estado = 4'h7;
            end
            FIM_GANHOU: begin
                pronto = 1'b1; ganhou = 1'b1;
                db_estado = 4'hA;
            end
            FIM_PERDEU: begin
                pronto = 1'b1; perdeu = 1'b1;
                db_estado = 4'hE;
            end
            FIM_TIMEOUT: begin
                pronto = 1'b1; perdeu = 1'b1; db_timeout = 1'b1;
                db_estado = 4'hB;
            end
            default: db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// Bench for unidade_controle_rodadas. Instance "dut" has an 8-cycle timeout and
// is followed every cycle by a game-level reference model; instance "dut_b"
// has the timeout disabled and gets a few directed checks.
// -----------------------------------------------------------------------------
module tb_unidade_controle_rodadas;

    localparam int TCIC = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- instance with timeout enabled ----------------
    logic reset_n = 1'b0, iniciar = 1'b0, jogada = 1'b0;
    logic igual = 1'b0, fimE = 1'b0, fimL = 1'b0;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    unidade_controle_rodadas #(.TIMEOUT_EN(1'b1), .TIMEOUT_CICLOS(TCIC)) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimL(fimL),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
        .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout),
        .db_estado(db_estado)
    );

    // ---------------- instance with timeout disabled ----------------
    logic reset_n_b = 1'b0, iniciar_b = 1'b0, jogada_b = 1'b0;
    logic igual_b = 1'b0, fimE_b = 1'b0, fimL_b = 1'b0;
    logic zeraE_b, contaE_b, zeraL_b, contaL_b, zeraR_b, registraR_b;
    logic pronto_b, ganhou_b, perdeu_b, db_timeout_b;
    logic [3:0] db_estado_b;

    unidade_controle_rodadas #(.TIMEOUT_EN(1'b0), .TIMEOUT_CICLOS(TCIC)) dut_b (
        .clock(clock), .reset_n(reset_n_b), .iniciar(iniciar_b), .jogada(jogada_b),
        .igual(igual_b), .fimE(fimE_b), .fimL(fimL_b),
        .zeraE(zeraE_b), .contaE(contaE_b), .zeraL(zeraL_b), .contaL(contaL_b),
        .zeraR(zeraR_b), .registraR(registraR_b), .pronto(pronto_b),
        .ganhou(ganhou_b), .perdeu(perdeu_b), .db_timeout(db_timeout_b),
        .db_estado(db_estado_b)
    );

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- game-level reference model ----------------
    // m_state holds the expected debug code; m_wait is the number of cycles
    // the player has already spent on the current move.
    int m_state = 0;
    int m_wait  = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 0;
            m_wait  <= 0;
        end else begin
            case (m_state)
                0:  if (iniciar) m_state <= 1;
                1:  m_state <= 2;
                2:  begin m_state <= 3; m_wait <= 0; end
                3: begin
                    if (jogada)                 m_state <= 4;
                    else if (m_wait >= TCIC - 1) m_state <= 11;
                    else                        m_wait <= m_wait + 1;
                end
                4:  m_state <= 5;
                5: begin
                    if (!igual)            m_state <= 14;
                    else if (fimE && fimL) m_state <= 10;
                    else if (fimE)         m_state <= 7;
                    else                   m_state <= 6;
                end
                6:  begin m_state <= 3; m_wait <= 0; end
                7:  m_state <= 2;
                10, 11, 14: if (iniciar) m_state <= 1;
                default: m_state <= 0;
            endcase
        end
    end

    // Expected flag vector for a debug code:
    // {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,ganhou,perdeu,db_timeout}
    function automatic logic [9:0] flags_of(input int s);
        logic [9:0] f;
        f[9] = (s == 0 || s == 1 || s == 2);
        f[8] = (s == 6);
        f[7] = (s == 0 || s == 1);
        f[6] = (s == 7);
        f[5] = (s == 0 || s == 1);
        f[4] = (s == 4);
        f[3] = (s == 10 || s == 11 || s == 14);
        f[2] = (s == 10);
        f[1] = (s == 11 || s == 14);
        f[0] = (s == 11);
        return f;
    endfunction

    logic cmp_en = 1'b0;
    always @(negedge clock) begin
        if (cmp_en) begin
            check("estado_modelo", {28'd0, db_estado}, 32'(m_state));
            check("saidas_modelo",
                  {22'd0, zeraE, contaE, zeraL, contaL, zeraR, registraR,
                   pronto, ganhou, perdeu, db_timeout},
                  {22'd0, flags_of(m_state)});
        end
    end

    // Pulse counters for the win scenario.
    logic cnt_en = 1'b0;
    int   n_contaE = 0;
    int   n_contaL = 0;
    always @(negedge clock) begin
        if (cnt_en) begin
            if (contaE) n_contaE++;
            if (contaL) n_contaL++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge in inicial or a fim state; returns at the negedge
    // where espera_jogada is expected.
    task automatic start();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    // Called at a negedge in espera_jogada; returns in espera_jogada for
    // a continuing game, or in the final state.
    task automatic move(input logic ig, input logic fe, input logic fl);
        jogada = 1'b1; igual = ig; fimE = fe; fimL = fl;
        @(negedge clock);
        jogada = 1'b0;
        @(negedge clock);
        @(negedge clock);
        if (ig && !fe) begin
            @(negedge clock);
        end else if (ig && fe && !fl) begin
            @(negedge clock);
            @(negedge clock);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clock);
        reset_n   = 1'b1;
        reset_n_b = 1'b1;
        cmp_en    = 1'b1;

        // Reset / idle
        repeat (10) @(negedge clock);
        $display("idle: estado=%0h zeraE=%0b zeraL=%0b zeraR=%0b pronto=%0b",
                 db_estado, zeraE, zeraL, zeraR, pronto);
        check("idle_estado", {28'd0, db_estado}, 32'h0);
        check("idle_zeras", {29'd0, zeraE, zeraL, zeraR}, 32'h7);
        check("idle_pronto", {31'd0, pronto}, 32'h0);

        // Win over three rounds
        cnt_en = 1'b1;
        start();
        check("start_espera", {28'd0, db_estado}, 32'h3);
        move(1'b1, 1'b1, 1'b0);
        move(1'b1, 1'b0, 1'b0);
        move(1'b1, 1'b1, 1'b0);
        move(1'b1, 1'b0, 1'b1);
        move(1'b1, 1'b0, 1'b1);
        move(1'b1, 1'b1, 1'b1);
        cnt_en = 1'b0;
        $display("win: estado=%0h ganhou=%0b pronto=%0b contaE=%0d contaL=%0d",
                 db_estado, ganhou, pronto, n_contaE, n_contaL);
        check("win_estado", {28'd0, db_estado}, 32'hA);
        check("win_ganhou_pronto", {30'd0, ganhou, pronto}, 32'h3);
        check("win_contaE_count", 32'(n_contaE), 32'd3);
        check("win_contaL_count", 32'(n_contaL), 32'd2);

        // Wrong move on the second move of round 1
        start();
        move(1'b1, 1'b1, 1'b0);
        move(1'b1, 1'b0, 1'b0);
        move(1'b0, 1'b0, 1'b0);
        $display("wrong: estado=%0h perdeu=%0b ganhou=%0b", db_estado, perdeu, ganhou);
        check("wrong_estado", {28'd0, db_estado}, 32'hE);
        check("wrong_perdeu_ganhou", {30'd0, perdeu, ganhou}, 32'h2);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        $display("restart: estado=%0h zeraL=%0b", db_estado, zeraL);
        check("restart_estado", {28'd0, db_estado}, 32'h1);
        check("restart_zeraL", {31'd0, zeraL}, 32'h1);
        @(negedge clock);
        @(negedge clock);

        // Timeout: 8 clocks after entering espera_jogada
        repeat (TCIC - 1) @(negedge clock);
        check("timeout_before", {28'd0, db_estado}, 32'h3);
        @(negedge clock);
        $display("timeout: estado=%0h perdeu=%0b db_timeout=%0b", db_estado, perdeu, db_timeout);
        check("timeout_estado", {28'd0, db_estado}, 32'hB);
        check("timeout_flags", {30'd0, perdeu, db_timeout}, 32'h3);

        // Move on the last allowed cycle beats the timeout
        start();
        repeat (TCIC - 1) @(negedge clock);
        jogada = 1'b1; igual = 1'b0;
        @(negedge clock);
        jogada = 1'b0;
        $display("late_move: estado=%0h db_timeout=%0b", db_estado, db_timeout);
        check("late_move_registra", {28'd0, db_estado}, 32'h4);
        check("late_move_registraR", {31'd0, registraR}, 32'h1);
        @(negedge clock);
        @(negedge clock);
        check("late_move_perdeu", {28'd0, db_estado}, 32'hE);
        check("late_move_no_timeout", {31'd0, db_timeout}, 32'h0);

        // Asynchronous reset in comparacao
        start();
        jogada = 1'b1; igual = 1'b1; fimE = 1'b0; fimL = 1'b0;
        @(negedge clock);
        jogada = 1'b0;
        @(negedge clock);
        check("pre_reset_comparacao", {28'd0, db_estado}, 32'h5);
        #2 reset_n = 1'b0;
        #1;
        $display("async_reset: estado=%0h zeraE=%0b", db_estado, zeraE);
        check("async_reset_estado", {28'd0, db_estado}, 32'h0);
        check("async_reset_zeraE", {31'd0, zeraE}, 32'h1);
        @(negedge clock);
        reset_n = 1'b1;
        start();
        $display("after_reset: estado=%0h", db_estado);
        check("after_reset_espera", {28'd0, db_estado}, 32'h3);

        // Timeout disabled: waits indefinitely
        iniciar_b = 1'b1;
        @(negedge clock);
        iniciar_b = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("noto_espera", {28'd0, db_estado_b}, 32'h3);
        repeat (2 * TCIC) @(negedge clock);
        $display("no_timeout: estado=%0h perdeu=%0b", db_estado_b, perdeu_b);
        check("noto_still_espera", {28'd0, db_estado_b}, 32'h3);
        check("noto_perdeu", {31'd0, perdeu_b}, 32'h0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Parametrised Moore control unit for the memory game: round-based play where round k requires the player to repeat positions 0..k of the stored sequence. Adds a per-move timeout and a third terminal outcome. It sits beside the datapath and drives the move counter (E), the round-limit counter (L) and the move register (R). It consumes the datapath status flags `igual`, `fimE` and `fimL`.

## Interface
- `TIMEOUT_EN`, default 1: 1 enables the per-move timeout; 0 means the block waits indefinitely in `espera_jogada`.
- `TIMEOUT_CICLOS`, default 5000: clock cycles allowed per move. Must be ≥ 2. Internal timer width is `$clog2(TIMEOUT_CICLOS)`.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low; forces state `inicial` and clears the timer.
- `iniciar` in 1: level; starts or restarts a game from `inicial` or any final state.
- `jogada` in 1: one-cycle pulse, already edge-detected, meaning a move was made.
- `igual` in 1: registered move equals memory contents at address E.
- `fimE` in 1: E == L, the last move of the current round.
- `fimL` in 1: L at maximum, the last round.
- `zeraE`, `contaE` out 1: clear / increment counter E.
- `zeraL`, `contaL` out 1: clear / increment counter L.
- `zeraR`, `registraR` out 1: clear / load move register R.
- `pronto` out 1: game over, any outcome.
- `ganhou` out 1: won.
- `perdeu` out 1: lost, by wrong move or by timeout.
- `db_timeout` out 1: the loss was by timeout.
- `db_estado` out 4: state code, for debug.

## Operation
- State register is reset-only. Next-state logic and outputs are combinational from state (Moore); the only exception is that the timer compare also feeds next-state logic.
- States and `db_estado` codes:
  - `inicial` = 0
  - `preparacao` = 1
  - `inicio_rodada` = 2
  - `espera_jogada` = 3
  - `registra` = 4
  - `comparacao` = 5
  - `proximo` = 6
  - `fim_rodada` = 7
  - `fim_ganhou` = A
  - `fim_perdeu` = E
  - `fim_timeout` = B
  - Any illegal encoding shows F and goes to `inicial` on the next clock.
- Transitions:
  - `inicial` → `preparacao` if `iniciar`.
  - `preparacao` → `inicio_rodada`.
  - `inicio_rodada` → `espera_jogada`.
  - `espera_jogada` → `registra` if `jogada`; else → `fim_timeout` if `TIMEOUT_EN` and timer == `TIMEOUT_CICLOS`-1; else stay.
  - `registra` → `comparacao`.
  - `comparacao`:
    - `!igual` → `fim_perdeu`.
    - `igual & fimE & fimL` → `fim_ganhou`.
    - `igual & fimE & !fimL` → `fim_rodada`.
    - otherwise → `proximo`.
  - `proximo` → `espera_jogada`.
  - `fim_rodada` → `inicio_rodada`.
  - `fim_ganhou`, `fim_perdeu`, `fim_timeout` → `preparacao` if `iniciar`, else stay.
- Outputs, each 1 only in the listed states:
  - `zeraE`: `inicial`, `preparacao`, `inicio_rodada`.
  - `zeraL`, `zeraR`: `inicial`, `preparacao`.
  - `registraR`: `registra`.
  - `contaE`: `proximo`.
  - `contaL`: `fim_rodada`.
  - `pronto`: all three fim states.
  - `ganhou`: `fim_ganhou`.
  - `perdeu`: `fim_perdeu`, `fim_timeout`.
  - `db_timeout`: `fim_timeout`.
- Timer:
  - Held at 0 outside `espera_jogada`.
  - Increments every cycle in `espera_jogada`.
  - Saturates at `TIMEOUT_CICLOS`-1; it never wraps.
  - Restarts from 0 for every move, because `proximo` and `inicio_rodada` both leave `espera_jogada`.

## Timing
- Reset values (state `inicial`, timer 0):
  - `zeraE` = `zeraL` = `zeraR` = 1.
  - All other outputs 0.
  - `db_estado` = 0.
- `reset_n` low mid-game takes effect immediately, asynchronously; all final flags drop without waiting for a clock.
- From `iniciar` sampled high in `inicial` to first `espera_jogada`: 3 clocks (`preparacao`, `inicio_rodada`, `espera_jogada`).
- Move latency: `jogada` high in `espera_jogada` at edge t:
  - `registraR` is high during t..t+1.
  - The `comparacao` decision is taken at edge t+2.
  - `contaE` (non-final move) is high for exactly 1 cycle.
- Timeout: entering `espera_jogada` at edge t with no `jogada` gives `fim_timeout` at edge t+`TIMEOUT_CICLOS`.
- `jogada` and the timeout condition in the same cycle: `jogada` wins.
- A `jogada` pulse outside `espera_jogada` is ignored.
- `iniciar` held high through a fim state restarts the game; `iniciar` outside `inicial` and the fim states is ignored.
- Round boundary: the last correct move of a non-final round gives `contaL` for 1 cycle, then `zeraE` for 1 cycle, then `espera_jogada`. `contaE` is not asserted on that move.

## Test plan
- Reset/idle: `reset_n`=0, then release with `iniciar`=0 for 10 clocks → `db_estado`=0, `zeraE`=`zeraL`=`zeraR`=1, `pronto`=0.
- Win, with `fimL` asserted in round 2 (3 rounds total, rounds 0..2): drive correct moves (1, 2, then 3 per round) with `igual`=1 and `fimE` timed per move → `contaL` seen 2 times, `contaE` seen 0+1+2=3 times, final `db_estado`=A, `ganhou`=1, `pronto`=1.
- Wrong move: `igual`=0 on the second move of round 1 → `db_estado`=E, `perdeu`=1, `ganhou`=0. Then `iniciar`=1 → `preparacao`, with `zeraL`=1.
- Timeout with `TIMEOUT_CICLOS`=8: no `jogada` after entering `espera_jogada` → exactly 8 clocks later `db_estado`=B, `perdeu`=1, `db_timeout`=1. Repeat the wait with `jogada` on the 8th cycle (timer=7) → `registra`, no timeout.
- `TIMEOUT_EN`=0: wait 2×`TIMEOUT_CICLOS` with no `jogada` → state remains 3.
- Async reset mid-game: `reset_n` falls between clock edges while in `comparacao` → `db_estado`=0 immediately; the next game starts normally.
